reset_sequencer: RTL

Parametrised successor to the single-output power-on reset generator.
- Qualifies the PLL lock with a 2-flop synchroniser and a consecutive-sample debounce filter.
- Holds all downstream resets for a programmable time, then releases N_OUT active-high reset outputs one after another at a fixed stagger.
- Re-enters sequencing on lock loss or on a software reset request, and records lock loss in a sticky flag.
- Sits at the top level between the PLL and all clocked subsystems (sensor front-end, processing core, output interface).

---
 rtl/reset_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: qualifies PLL lock, holds all downstream resets for a fixed
// time, then releases them in ascending order at a fixed stagger.
module reset_sequencer #(
    parameter int N_OUT       = 4,
    parameter int LOCK_CYC    = 16,
    parameter int HOLD_CYC    = 32768,
    parameter int STAGGER_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             sw_reset_req,
    input  logic             lock_lost_clr,
    output logic [N_OUT-1:0] hw_reset,
    output logic             ready,
    output logic             lock_lost,
    output logic [1:0]       seq_state
);

    localparam int LOCK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int STAG_W = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
    localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_OUT - 1);
    localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'((N_OUT > 1) ? 1 : 0);
    localparam logic [N_OUT-1:0]  ALL_ASSERTED = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               pll_meta_q, pll_locked_s;
    logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [STAG_W-1:0]  stag_cnt_q, stag_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_OUT-1:0]   hw_reset_d;
    logic               ready_d, lock_lost_d;
    logic               bad_cnt;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            pll_meta_q   <= 1'b0;
            pll_locked_s <= 1'b0;
            state_q      <= WAIT_LOCK;
            lock_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            stag_cnt_q   <= '0;
            idx_q        <= '0;
            hw_reset     <= ALL_ASSERTED;
            ready        <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            pll_meta_q   <= pll_locked;
            pll_locked_s <= pll_meta_q;
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            stag_cnt_q   <= stag_cnt_d;
            idx_q        <= idx_d;
            hw_reset     <= hw_reset_d;
            ready        <= ready_d;
            lock_lost    <= lock_lost_d;
        end
    end

    assign seq_state = state_q;

    // Counter values that no legal sequence can produce force a clean restart.
    assign bad_cnt = (int'(lock_cnt_q) >= LOCK_CYC) || (int'(hold_cnt_q) >= HOLD_CYC) ||
                     (int'(stag_cnt_q) >= STAGGER_CYC) || (int'(idx_q) >= N_OUT);

    always_comb begin
        // NOTE: every variable gets a default first so no branch can infer a latch.
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        stag_cnt_d  = stag_cnt_q;
        idx_d       = idx_q;
        hw_reset_d  = hw_reset;
        ready_d     = ready;
        lock_lost_d = lock_lost & ~lock_lost_clr;

        case (state_q)
            WAIT_LOCK: begin
                hw_reset_d = ALL_ASSERTED;
                ready_d    = 1'b0;
                if (!pll_locked_s) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = HOLD;
                    lock_cnt_d = '0;
                    hold_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                hw_reset_d = ALL_ASSERTED;
                ready_d    = 1'b0;
                if (hold_cnt_q == HOLD_LAST) begin
                    hw_reset_d[0] = 1'b0;
                    hold_cnt_d    = '0;
                    stag_cnt_d    = '0;
                    idx_d         = IDX_FIRST;
                    ready_d       = (N_OUT == 1);
                    state_d       = (N_OUT == 1) ? RUN : RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (stag_cnt_q == STAG_LAST) begin
                    // Clearing every bit up to idx keeps releases strictly ascending.
                    for (int i = 0; i < N_OUT; i++)
                        if (i <= int'(idx_q)) hw_reset_d[i] = 1'b0;
                    stag_cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        ready_d = 1'b1;
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    stag_cnt_d = stag_cnt_q + 1'b1;
                end
            end
            RUN: begin
                hw_reset_d = '0;
                ready_d    = 1'b1;
            end
            default: begin
                state_d    = WAIT_LOCK;
                hw_reset_d = ALL_ASSERTED;
                ready_d    = 1'b0;
            end
        endcase

        if (bad_cnt) begin
            state_d    = WAIT_LOCK;
            lock_cnt_d = '0;
            hold_cnt_d = '0;
            stag_cnt_d = '0;
            idx_d      = '0;
            hw_reset_d = ALL_ASSERTED;
            ready_d    = 1'b0;
        end

        if (state_q != WAIT_LOCK) begin
            if (!pll_locked_s) begin
                state_d     = WAIT_LOCK;
                lock_cnt_d  = '0;
                hw_reset_d  = ALL_ASSERTED;
                ready_d     = 1'b0;
                lock_lost_d = 1'b1;
            end else if (sw_reset_req) begin
                state_d    = HOLD;
                hold_cnt_d = '0;
                stag_cnt_d = '0;
                idx_d      = '0;
                hw_reset_d = ALL_ASSERTED;
                ready_d    = 1'b0;
            end
        end
    end

endmodule
